// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_port_arbiter_pkg;

    localparam int FUNCT3_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic {
        GNT_CORE,
        GNT_AUX
    } arb_grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - core/aux request buses and memory port bundle
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import mem_port_arbiter_pkg::*;

    logic                core_req_valid;
    logic                core_req_ready;
    logic [ADDR_W-1:0]   core_addr;
    logic [DATA_W-1:0]   core_wdata;
    logic                core_wren;
    logic [FUNCT3_W-1:0] core_funct3;
    logic                core_rsp_valid;
    logic [DATA_W-1:0]   core_rdata;

    logic                aux_req_valid;
    logic                aux_req_ready;
    logic [ADDR_W-1:0]   aux_addr;
    logic [DATA_W-1:0]   aux_wdata;
    logic                aux_wren;
    logic [FUNCT3_W-1:0] aux_funct3;
    logic                aux_rsp_valid;
    logic [DATA_W-1:0]   aux_rdata;

    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_wren;
    logic [FUNCT3_W-1:0] mem_funct3;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  core_req_valid, core_addr, core_wdata, core_wren, core_funct3,
        output core_req_ready, core_rsp_valid, core_rdata,
        input  aux_req_valid, aux_addr, aux_wdata, aux_wren, aux_funct3,
        output aux_req_ready, aux_rsp_valid, aux_rdata,
        output mem_addr, mem_wdata, mem_wren, mem_funct3,
        input  mem_rdata
    );

    modport master (
        output core_req_valid, core_addr, core_wdata, core_wren, core_funct3,
        input  core_req_ready, core_rsp_valid, core_rdata,
        output aux_req_valid, aux_addr, aux_wdata, aux_wren, aux_funct3,
        input  aux_req_ready, aux_rsp_valid, aux_rdata,
        input  mem_addr, mem_wdata, mem_wren, mem_funct3,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// rtl/mem_port_arbiter_arb_pick.sv - combinational winner select between core and aux
// MEM_ARB_RR_EN selects round-robin on ties; otherwise core has fixed priority.
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic       core_valid_i,
    input  logic       aux_valid_i,
`ifdef MEM_ARB_RR_EN
    input  arb_grant_t last_grant_i,
`endif
    output logic       grant_valid_o,
    output arb_grant_t grant_o
);

    always_comb begin
        grant_valid_o = core_valid_i | aux_valid_i;
        grant_o       = GNT_CORE;
        if (core_valid_i && aux_valid_i) begin
`ifdef MEM_ARB_RR_EN
            grant_o = (last_grant_i == GNT_CORE) ? GNT_AUX : GNT_CORE;
`else
            grant_o = GNT_CORE;
`endif
        end else if (aux_valid_i) begin
            grant_o = GNT_AUX;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the unified synchronous-read memory port
// Optional MEM_ARB_RR_EN enables round-robin tie breaking (fixed core priority otherwise).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    arb_state_t          state_q;
    arb_grant_t          owner_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                mem_wren_q;
    logic [FUNCT3_W-1:0] mem_funct3_q;
    logic                core_rsp_q;
    logic                aux_rsp_q;

    logic                pick_valid;
    arb_grant_t          pick_grant;
    logic                handshake;

    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                wren_d;
    logic [FUNCT3_W-1:0] funct3_d;

`ifdef MEM_ARB_RR_EN
    arb_grant_t          last_grant_q;
`endif

    arb_pick u_pick (
        .core_valid_i  (bus.core_req_valid),
        .aux_valid_i   (bus.aux_req_valid),
`ifdef MEM_ARB_RR_EN
        .last_grant_i  (last_grant_q),
`endif
        .grant_valid_o (pick_valid),
        .grant_o       (pick_grant)
    );

    // Ready is gated by reset so nothing looks accepted while reset is held.
    assign handshake = reset && (state_q == IDLE) && pick_valid;

    assign bus.core_req_ready = handshake && (pick_grant == GNT_CORE);
    assign bus.aux_req_ready  = handshake && (pick_grant == GNT_AUX);

    always_comb begin
        addr_d   = bus.core_addr;
        wdata_d  = bus.core_wdata;
        wren_d   = bus.core_wren;
        funct3_d = bus.core_funct3;
        if (pick_grant == GNT_AUX) begin
            addr_d   = bus.aux_addr;
            wdata_d  = bus.aux_wdata;
            wren_d   = bus.aux_wren;
            funct3_d = bus.aux_funct3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= GNT_CORE;
            wr_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wren_q   <= 1'b0;
            mem_funct3_q <= '0;
            core_rsp_q   <= 1'b0;
            aux_rsp_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= GNT_AUX;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        state_q      <= ACCESS;
                        owner_q      <= pick_grant;
                        wr_q         <= wren_d;
                        mem_addr_q   <= addr_d;
                        mem_wdata_q  <= wdata_d;
                        mem_wren_q   <= wren_d;
                        mem_funct3_q <= funct3_d;
`ifdef MEM_ARB_RR_EN
                        last_grant_q <= pick_grant;
`endif
                    end
                end
                ACCESS: begin
                    state_q      <= RESP;
                    mem_addr_q   <= '0;
                    mem_wdata_q  <= '0;
                    mem_wren_q   <= 1'b0;
                    mem_funct3_q <= '0;
                    core_rsp_q   <= (owner_q == GNT_CORE);
                    aux_rsp_q    <= (owner_q == GNT_AUX);
                end
                default: begin
                    state_q    <= IDLE;
                    core_rsp_q <= 1'b0;
                    aux_rsp_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wren   = mem_wren_q;
    assign bus.mem_funct3 = mem_funct3_q;

    // Memory read data arrives during RESP, so it is steered combinationally.
    assign bus.core_rsp_valid = core_rsp_q;
    assign bus.aux_rsp_valid  = aux_rsp_q;
    assign bus.core_rdata     = (core_rsp_q && !wr_q) ? bus.mem_rdata : '0;
    assign bus.aux_rdata      = (aux_rsp_q && !wr_q) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic preload;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:255];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[64] <= 32'h1234_5678;
            mem[16] <= 32'h0BAD_F00D;
            bus.mem_rdata <= 32'h0;
        end else begin
            if (bus.mem_wren) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.core_req_valid = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
        bus.core_wren = 1'b0; bus.core_funct3 = '0;
        bus.aux_req_valid = 1'b0; bus.aux_addr = '0; bus.aux_wdata = '0;
        bus.aux_wren = 1'b0; bus.aux_funct3 = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.core_req_valid = 1'b1;
        bus.aux_req_valid  = 1'b1;
        @(negedge clk);
        total++; if ({bus.core_req_ready, bus.aux_req_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", {bus.core_req_ready, bus.aux_req_ready}); end
        total++; if ({bus.core_rsp_valid, bus.aux_rsp_valid} !== 2'b00) begin bad++; $display("FAIL reset_rsp got=%b exp=00", {bus.core_rsp_valid, bus.aux_rsp_valid}); end
        total++; if ((bus.core_rdata | bus.aux_rdata) !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.core_rdata | bus.aux_rdata); end
        total++; if ({bus.mem_wren, bus.mem_addr, bus.mem_wdata, bus.mem_funct3} !== '0) begin bad++; $display("FAIL reset_mem got=%b/%h/%h/%h exp=0", bus.mem_wren, bus.mem_addr, bus.mem_wdata, bus.mem_funct3); end
        cyc();
        drive_idle();
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_core_read();
        bus.core_req_valid = 1'b1; bus.core_addr = 32'h100; bus.core_wren = 1'b0; bus.core_funct3 = 3'b010;
        @(negedge clk);
        total++; if ({bus.core_req_ready, bus.aux_req_ready} !== 2'b10) begin bad++; $display("FAIL rd_ready got=%b exp=10", {bus.core_req_ready, bus.aux_req_ready}); end
        cyc();
        bus.core_req_valid = 1'b0; bus.core_addr = 32'h0;
        @(negedge clk);
        total++; if (bus.mem_addr !== 32'h100) begin bad++; $display("FAIL rd_mem_addr got=%h exp=00000100", bus.mem_addr); end
        total++; if (bus.mem_wren !== 1'b0) begin bad++; $display("FAIL rd_mem_wren got=%b exp=0", bus.mem_wren); end
        total++; if (bus.mem_funct3 !== 3'b010) begin bad++; $display("FAIL rd_funct3 got=%b exp=010", bus.mem_funct3); end
        total++; if ({bus.core_rsp_valid, bus.aux_rsp_valid} !== 2'b00) begin bad++; $display("FAIL rd_rsp_early got=%b exp=00", {bus.core_rsp_valid, bus.aux_rsp_valid}); end
        cyc();
        @(negedge clk);
        total++; if ({bus.core_rsp_valid, bus.aux_rsp_valid} !== 2'b10) begin bad++; $display("FAIL rd_rsp got=%b exp=10", {bus.core_rsp_valid, bus.aux_rsp_valid}); end
        total++; if (bus.core_rdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_rdata got=%h exp=12345678", bus.core_rdata); end
        total++; if (bus.aux_rdata !== 32'h0) begin bad++; $display("FAIL rd_aux_rdata got=%h exp=0", bus.aux_rdata); end
        total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rd_mem_idle got=%h exp=0", bus.mem_addr); end
        cyc();
        @(negedge clk);
        total++; if (bus.core_rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_rsp_pulse got=%b exp=0", bus.core_rsp_valid); end
        cyc();
    endtask

    task automatic test_aux_write();
        bus.aux_req_valid = 1'b1; bus.aux_addr = 32'h20; bus.aux_wdata = 32'hDEAD_BEEF;
        bus.aux_wren = 1'b1; bus.aux_funct3 = 3'b010;
        @(negedge clk);
        total++; if ({bus.core_req_ready, bus.aux_req_ready} !== 2'b01) begin bad++; $display("FAIL wr_ready got=%b exp=01", {bus.core_req_ready, bus.aux_req_ready}); end
        total++; if (bus.mem_wren !== 1'b0) begin bad++; $display("FAIL wr_wren_T got=%b exp=0", bus.mem_wren); end
        cyc();
        drive_idle();
        @(negedge clk);
        total++; if ({bus.mem_wren, bus.mem_addr, bus.mem_wdata, bus.mem_funct3} !== {1'b1, 32'h20, 32'hDEAD_BEEF, 3'b010}) begin bad++; $display("FAIL wr_mem got=%b/%h/%h/%b exp=1/00000020/deadbeef/010", bus.mem_wren, bus.mem_addr, bus.mem_wdata, bus.mem_funct3); end
        cyc();
        @(negedge clk);
        total++; if (bus.mem_wren !== 1'b0) begin bad++; $display("FAIL wr_wren_T2 got=%b exp=0", bus.mem_wren); end
        total++; if ({bus.core_rsp_valid, bus.aux_rsp_valid} !== 2'b01) begin bad++; $display("FAIL wr_rsp got=%b exp=01", {bus.core_rsp_valid, bus.aux_rsp_valid}); end
        total++; if (bus.aux_rdata !== 32'h0) begin bad++; $display("FAIL wr_rdata got=%h exp=0", bus.aux_rdata); end
        cyc();
        bus.core_req_valid = 1'b1; bus.core_addr = 32'h20; bus.core_wren = 1'b0; bus.core_funct3 = 3'b010;
        @(negedge clk);
        total++; if (bus.core_req_ready !== 1'b1) begin bad++; $display("FAIL wr_rb_ready got=%b exp=1", bus.core_req_ready); end
        cyc();
        drive_idle();
        cyc();
        @(negedge clk);
        total++; if (bus.core_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_readback got=%h exp=deadbeef", bus.core_rdata); end
        cyc();
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        int last_hs = 0;
        logic [1:0] exp_rdy;
        bit found;
        bus.core_req_valid = 1'b1; bus.core_addr = 32'h100;
        bus.aux_req_valid  = 1'b1; bus.aux_addr  = 32'h20;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_rdy = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_rdy = 2'b10;
`endif
            found = 1'b0;
            for (int w = 0; w < 6 && !found; w++) begin
                @(negedge clk);
                if (bus.core_req_ready || bus.aux_req_ready) begin
                    found = 1'b1;
                    total++; if ({bus.core_req_ready, bus.aux_req_ready} !== exp_rdy) begin bad++; $display("FAIL b2b_grant%0d got=%b exp=%b", k, {bus.core_req_ready, bus.aux_req_ready}, exp_rdy); end
                    if (k > 0) begin
                        total++; if (cnt - last_hs !== 3) begin bad++; $display("FAIL b2b_gap%0d got=%0d exp=3", k, cnt - last_hs); end
                    end
                    last_hs = cnt;
                end
                cyc();
                cnt++;
            end
            if (!found) begin
                total++; bad++;
                $display("FAIL b2b_timeout%0d got=no_ready exp=ready", k);
            end
        end
        drive_idle();
        cyc(); cyc(); cyc();
    endtask

    task automatic test_req_during_access();
        bus.core_req_valid = 1'b1; bus.core_addr = 32'h100;
        @(negedge clk);
        total++; if (bus.core_req_ready !== 1'b1) begin bad++; $display("FAIL rda_core_ready got=%b exp=1", bus.core_req_ready); end
        cyc();
        bus.core_req_valid = 1'b0;
        bus.aux_req_valid = 1'b1; bus.aux_addr = 32'h20; bus.aux_wren = 1'b0;
        @(negedge clk);
        total++; if (bus.aux_req_ready !== 1'b0) begin bad++; $display("FAIL rda_ready_T1 got=%b exp=0", bus.aux_req_ready); end
        cyc();
        @(negedge clk);
        total++; if (bus.aux_req_ready !== 1'b0) begin bad++; $display("FAIL rda_ready_T2 got=%b exp=0", bus.aux_req_ready); end
        cyc();
        @(negedge clk);
        total++; if (bus.aux_req_ready !== 1'b1) begin bad++; $display("FAIL rda_ready_T3 got=%b exp=1", bus.aux_req_ready); end
        cyc();
        drive_idle();
        @(negedge clk);
        total++; if (bus.mem_addr !== 32'h20) begin bad++; $display("FAIL rda_mem_addr got=%h exp=00000020", bus.mem_addr); end
        cyc();
        @(negedge clk);
        total++; if ({bus.core_rsp_valid, bus.aux_rsp_valid} !== 2'b01) begin bad++; $display("FAIL rda_rsp got=%b exp=01", {bus.core_rsp_valid, bus.aux_rsp_valid}); end
        total++; if (bus.aux_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rda_rdata got=%h exp=deadbeef", bus.aux_rdata); end
        total++; if (bus.core_rdata !== 32'h0) begin bad++; $display("FAIL rda_core_rdata got=%h exp=0", bus.core_rdata); end
        cyc();
    endtask

    task automatic test_reset_mid();
        bus.core_req_valid = 1'b1; bus.core_addr = 32'h40; bus.core_wdata = 32'h55AA_55AA;
        bus.core_wren = 1'b1; bus.core_funct3 = 3'b010;
        @(negedge clk);
        total++; if (bus.core_req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.core_req_ready); end
        cyc();
        drive_idle();
        @(negedge clk);
        total++; if (bus.mem_wren !== 1'b1) begin bad++; $display("FAIL rst_wren_pre got=%b exp=1", bus.mem_wren); end
        #1 reset = 1'b0;
        #1;
        total++; if ({bus.mem_wren, bus.mem_addr} !== {1'b0, 32'h0}) begin bad++; $display("FAIL rst_async got=%b/%h exp=0/0", bus.mem_wren, bus.mem_addr); end
        cyc();
        @(negedge clk);
        total++; if (bus.core_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp1 got=%b exp=0", bus.core_rsp_valid); end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        total++; if (bus.core_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp2 got=%b exp=0", bus.core_rsp_valid); end
        cyc();
        bus.core_req_valid = 1'b1; bus.core_addr = 32'h40; bus.core_wren = 1'b0;
        @(negedge clk);
        total++; if (bus.core_req_ready !== 1'b1) begin bad++; $display("FAIL rst_after_ready got=%b exp=1", bus.core_req_ready); end
        cyc();
        drive_idle();
        cyc();
        @(negedge clk);
        total++; if ({bus.core_rsp_valid, bus.core_rdata} !== {1'b1, 32'h0BAD_F00D}) begin bad++; $display("FAIL rst_after_rd got=%b/%h exp=1/0badf00d", bus.core_rsp_valid, bus.core_rdata); end
        cyc();
    endtask

    task automatic test_valid_drop();
        int aux_rsp_n = 0;
        int core_rsp_n = 0;
        int spurious = 0;
        bus.core_req_valid = 1'b1; bus.core_addr = 32'h100;
        @(negedge clk);
        total++; if (bus.core_req_ready !== 1'b1) begin bad++; $display("FAIL drop_core_ready got=%b exp=1", bus.core_req_ready); end
        cyc();
        bus.core_req_valid = 1'b0;
        bus.aux_req_valid = 1'b1; bus.aux_addr = 32'h60;
        @(negedge clk);
        total++; if (bus.aux_req_ready !== 1'b0) begin bad++; $display("FAIL drop_aux_ready got=%b exp=0", bus.aux_req_ready); end
        cyc();
        drive_idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.aux_rsp_valid) aux_rsp_n++;
            if (bus.core_rsp_valid) core_rsp_n++;
            if (bus.aux_req_ready || bus.mem_addr == 32'h60) spurious++;
            cyc();
        end
        total++; if (aux_rsp_n !== 0) begin bad++; $display("FAIL drop_aux_rsp got=%0d exp=0", aux_rsp_n); end
        total++; if (core_rsp_n !== 1) begin bad++; $display("FAIL drop_core_rsp got=%0d exp=1", core_rsp_n); end
        total++; if (spurious !== 0) begin bad++; $display("FAIL drop_aux_txn got=%0d exp=0", spurious); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        preload = 1'b1;
        reset   = 1'b0;
        drive_idle();
        cyc();
        preload = 1'b0;
        test_reset();
        test_core_read();
        test_aux_write();
        apply_reset();
        test_back_to_back();
        test_req_during_access();
        test_reset_mid();
        test_valid_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
